// File: rtl/mips_pkg.sv
// Shared MIPS encodings: operation selects, opcode/funct constants, descriptor
// payload and the instruction encoder used by the loader.
package mips_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned TGT_W  = 26;
  localparam int unsigned OPC_W  = 6;

  typedef enum logic [SEL_W-1:0] {
    SEL_ADD  = 4'd0,
    SEL_ADDU = 4'd1,
    SEL_AND  = 4'd2,
    SEL_OR   = 4'd3,
    SEL_NOR  = 4'd4,
    SEL_SUB  = 4'd5,
    SEL_ADDI = 4'd6,
    SEL_ANDI = 4'd7,
    SEL_BEQ  = 4'd8,
    SEL_LW   = 4'd9,
    SEL_SW   = 4'd10,
    SEL_J    = 4'd11
  } op_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } load_state_e;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OP_J     = 6'b000010;

  localparam logic [OPC_W-1:0] FN_ADD  = 6'b100000;
  localparam logic [OPC_W-1:0] FN_ADDU = 6'b100001;
  localparam logic [OPC_W-1:0] FN_AND  = 6'b100100;
  localparam logic [OPC_W-1:0] FN_OR   = 6'b100101;
  localparam logic [OPC_W-1:0] FN_NOR  = 6'b100111;
  localparam logic [OPC_W-1:0] FN_SUB  = 6'b100010;

  typedef struct packed {
    logic [SEL_W-1:0] op;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] shamt;
    logic [IMM_W-1:0] imm16;
    logic [TGT_W-1:0] target;
  } instr_desc_t;

  typedef struct packed {
    logic              legal;
    logic [WORD_W-1:0] word;
  } enc_t;

  function automatic logic [WORD_W-1:0] rtype_word(instr_desc_t d, logic [OPC_W-1:0] fn);
    return {OP_RTYPE, d.rs, d.rt, d.rd, d.shamt, fn};
  endfunction

  function automatic logic [WORD_W-1:0] itype_word(instr_desc_t d, logic [OPC_W-1:0] opc);
    return {opc, d.rs, d.rt, d.imm16};
  endfunction

  // Unused fields of each format are dropped; selects 12-15 are illegal.
  function automatic enc_t encode_instr(instr_desc_t d);
    enc_t e;
    e.legal = 1'b1;
    e.word  = '0;
    case (d.op)
      SEL_ADD:  e.word = rtype_word(d, FN_ADD);
      SEL_ADDU: e.word = rtype_word(d, FN_ADDU);
      SEL_AND:  e.word = rtype_word(d, FN_AND);
      SEL_OR:   e.word = rtype_word(d, FN_OR);
      SEL_NOR:  e.word = rtype_word(d, FN_NOR);
      SEL_SUB:  e.word = rtype_word(d, FN_SUB);
      SEL_ADDI: e.word = itype_word(d, OP_ADDI);
      SEL_ANDI: e.word = itype_word(d, OP_ANDI);
      SEL_BEQ:  e.word = itype_word(d, OP_BEQ);
      SEL_LW:   e.word = itype_word(d, OP_LW);
      SEL_SW:   e.word = itype_word(d, OP_SW);
      SEL_J:    e.word = {OP_J, d.target};
      default:  e.legal = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; push and pop may coincide at any
// occupancy, including full.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    count_d = count;
    if (do_push && !do_pop) count_d = count + CNT_W'(1);
    if (do_pop && !do_push) count_d = count - CNT_W'(1);
  end

  assign rd_data_c = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
      empty <= (count_d == '0);
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes symbolic instruction descriptors into MIPS words and
// writes them to instruction memory at consecutive word addresses.
module instr_encoder_loader
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm16,
  input  logic [25:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned FCNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W  = FCNT_W + 1;

  load_state_e        state_q;
  load_state_e        state_d;
  logic [CNT_W-1:0]   remaining_q;
  logic [ADDR_W-1:0]  next_addr_q;
  logic               stage_valid_q;
  logic [WORD_W-1:0]  stage_word_q;
  logic [OCC_W-1:0]   occ;
  logic               hs;
  instr_desc_t        desc;
  enc_t               enc;

  logic               fifo_push;
  logic               fifo_pop;
  logic [WORD_W-1:0]  fifo_rd_data;
  logic [FCNT_W-1:0]  fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               wr_fire;
  logic [WORD_W-1:0]  wr_word;

  assign desc = {op, rs, rt, rd, shamt, imm16, target};
  assign enc  = encode_instr(desc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    occ      = OCC_W'(fifo_count) + OCC_W'(stage_valid_q);
    if (state_q == ST_LOAD && remaining_q != '0 && occ < OCC_W'(DEPTH)) in_ready = 1'b1;
    hs = in_valid && in_ready;
    case (state_q)
      ST_IDLE:  if (start) state_d = (count == '0) ? ST_DONE : ST_LOAD;
      ST_LOAD:  if (hs && remaining_q == CNT_W'(1)) state_d = ST_DRAIN;
      ST_DRAIN: if (!stage_valid_q && fifo_empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // With an empty FIFO the stage word bypasses it straight to imem; otherwise
  // it queues behind the head so write order matches accept order.
  always_comb begin
    fifo_pop  = !fifo_empty;
    fifo_push = stage_valid_q && !fifo_empty && (!fifo_full || fifo_pop);
    wr_fire   = stage_valid_q || !fifo_empty;
    wr_word   = fifo_empty ? stage_word_q : fifo_rd_data;
  end

  sync_fifo #(
    .WIDTH(WORD_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .wr_data   (stage_word_q),
    .pop       (fifo_pop),
    .rd_data_c (fifo_rd_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_q   <= '0;
      err           <= 1'b0;
      stage_valid_q <= 1'b0;
      stage_word_q  <= '0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        remaining_q <= count;
        err         <= 1'b0;
      end else if (hs) begin
        remaining_q <= remaining_q - CNT_W'(1);
        if (!enc.legal) err <= 1'b1;
      end
      stage_valid_q <= hs && enc.legal;
      if (hs) stage_word_q <= enc.word;
    end
  end

  // Write port; the address advances only after a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_addr_q <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      imem_we <= wr_fire;
      if (state_q == ST_IDLE && start) begin
        next_addr_q <= base_addr;
      end else if (wr_fire) begin
        next_addr_q <= next_addr_q + ADDR_W'(4);
      end
      if (wr_fire) begin
        imem_addr  <= next_addr_q;
        imem_wdata <= wr_word;
      end
      busy <= (state_d != ST_IDLE);
      done <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: table-driven descriptors with
// a write scoreboard plus hand-written multi-cycle sequences.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] count = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [15:0] imm16 = '0;
  logic [25:0] target = '0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  instr_encoder_loader #(.DEPTH(4), .ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .imm16(imm16), .target(target), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int wr_cyc[$];
  wr_t exp_q[$];
  logic [31:0] exp_addr = '0;
  vec_t basic[5];
  vec_t allops[8];
  vec_t illeg[3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Write monitor: every imem write must match the scoreboard head.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && imem_we) begin
      wr_cnt++;
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=0x%08h@0x%08h required=none", imem_wdata, imem_addr);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", imem_addr, e.addr);
        chk("write_data", imem_wdata, e.data);
      end
    end
    if (rst_n && done) done_cnt++;
  end

  function automatic logic [31:0] model(input vec_t v, output logic legal);
    logic [5:0] fn;
    legal = 1'b1;
    fn = 6'h00;
    case (v.op)
      4'd0: fn = 6'h20;
      4'd1: fn = 6'h21;
      4'd2: fn = 6'h24;
      4'd3: fn = 6'h25;
      4'd4: fn = 6'h27;
      4'd5: fn = 6'h22;
      4'd6: return {6'h08, v.rs, v.rt, v.imm};
      4'd7: return {6'h0C, v.rs, v.rt, v.imm};
      4'd8: return {6'h04, v.rs, v.rt, v.imm};
      4'd9: return {6'h23, v.rs, v.rt, v.imm};
      4'd10: return {6'h2B, v.rs, v.rt, v.imm};
      4'd11: return {6'h02, v.tgt};
      default: begin legal = 1'b0; return 32'h0; end
    endcase
    return {6'h00, v.rs, v.rt, v.rd, v.shamt, fn};
  endfunction

  task automatic do_start(input logic [31:0] base, input logic [15:0] cnt, output int sc);
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    count = cnt;
    sc = cyc;
    exp_addr = base;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives one descriptor and leaves in_valid high; returns #1 after the accepting edge.
  task automatic send(input vec_t v, output int hs_c, output bit first_try);
    bit got;
    bit rdy;
    int c;
    got = 1'b0;
    first_try = 1'b0;
    hs_c = -1;
    @(negedge clk);
    op = v.op; rs = v.rs; rt = v.rt; rd = v.rd; shamt = v.shamt; imm16 = v.imm; target = v.tgt;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !got; t++) begin
      #1;
      rdy = in_ready;
      c = cyc;
      if (t == 0) first_try = rdy;
      @(posedge clk);
      if (rdy) begin
        got = 1'b1;
        hs_c = c;
      end else begin
        @(negedge clk);
      end
    end
    #1;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout actual=no_accept required=accept");
    end else if (v.legal) begin
      exp_q.push_back('{addr: exp_addr, data: v.word});
      exp_addr = exp_addr + 32'd4;
    end
  endtask

  task automatic wait_done(input int budget, output int dc);
    bit seen;
    seen = 1'b0;
    dc = -1;
    for (int t = 0; t < budget && !seen; t++) begin
      @(negedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        dc = cyc;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done");
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int sc, dc, hs, hs_first, w0, d0, wi;
    bit ft;
    int miss;
    vec_t v;
    logic lg;

    basic[0] = '{4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'h0, 1'b1, 32'h00221820};
    basic[1] = '{4'd6, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'h0, 1'b1, 32'h20080005};
    basic[2] = '{4'd9, 5'd29, 5'd9, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b1, 32'h8FA90004};
    basic[3] = '{4'd8, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b1, 32'h1022FFFF};
    basic[4] = '{4'd11, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h0000010, 1'b1, 32'h08000010};

    allops[0] = '{4'd5, 5'd4, 5'd5, 5'd6, 5'd0, 16'h1234, 26'h0, 1'b1, 32'h00853022};
    allops[1] = '{4'd2, 5'd7, 5'd8, 5'd9, 5'd0, 16'h0, 26'h3FFFFFF, 1'b1, 32'h00E84824};
    allops[2] = '{4'd3, 5'd31, 5'd31, 5'd31, 5'd31, 16'h0, 26'h0, 1'b1, 32'h03FFFFE5};
    allops[3] = '{4'd4, 5'd0, 5'd0, 5'd1, 5'd2, 16'h0, 26'h0, 1'b1, 32'h000008A7};
    allops[4] = '{4'd1, 5'd2, 5'd3, 5'd4, 5'd0, 16'h0, 26'h0, 1'b1, 32'h00432021};
    allops[5] = '{4'd7, 5'd1, 5'd2, 5'd31, 5'd31, 16'h00FF, 26'h0, 1'b1, 32'h302200FF};
    allops[6] = '{4'd10, 5'd29, 5'd31, 5'd0, 5'd0, 16'h8000, 26'h0, 1'b1, 32'hAFBF8000};
    allops[7] = '{4'd11, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h0BFFFFFF};

    illeg[0] = '{4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 32'h00221820};
    illeg[1] = '{4'd13, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 32'h0};
    illeg[2] = '{4'd5, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1'b1, 32'h00853022};

    // Reset values
    idle_cycles(3);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Basic encodes
    w0 = wr_cnt; d0 = done_cnt;
    do_start(32'h00400000, 16'd5, sc);
    chk("basic_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) send(basic[i], hs, ft);
    in_valid = 1'b0;
    wait_done(30, dc);
    idle_cycles(3);
    chk("basic_writes", 32'(wr_cnt - w0), 32'd5);
    chk("basic_done_once", 32'(done_cnt - d0), 32'd1);
    chk("basic_err", 32'(err), 32'd0);
    chk("basic_idle_busy", 32'(busy), 32'd0);
    chk("basic_sb_empty", 32'(exp_q.size()), 32'd0);

    // Every legal format, with unused fields populated
    w0 = wr_cnt;
    do_start(32'h00001000, 16'd8, sc);
    for (int i = 0; i < 8; i++) send(allops[i], hs, ft);
    in_valid = 1'b0;
    wait_done(30, dc);
    idle_cycles(2);
    chk("allops_writes", 32'(wr_cnt - w0), 32'd8);

    // Back-to-back throughput with random descriptors
    w0 = wr_cnt; wi = wr_cyc.size(); miss = 0; hs_first = 0;
    do_start(32'h00002000, 16'd8, sc);
    for (int i = 0; i < 8; i++) begin
      v.op = 4'($urandom_range(11));
      v.rs = 5'($urandom); v.rt = 5'($urandom); v.rd = 5'($urandom); v.shamt = 5'($urandom);
      v.imm = 16'($urandom); v.tgt = 26'($urandom);
      v.word = model(v, lg);
      v.legal = lg;
      send(v, hs, ft);
      if (i == 0) hs_first = hs;
      if (!ft) miss++;
    end
    in_valid = 1'b0;
    wait_done(30, dc);
    idle_cycles(2);
    chk("tput_ready_held", 32'(miss), 32'd0);
    chk("tput_writes", 32'(wr_cnt - w0), 32'd8);
    if (wr_cyc.size() >= wi + 8) begin
      chk("tput_first_latency", 32'(wr_cyc[wi] - hs_first), 32'd2);
      for (int i = 1; i < 8; i++) chk("tput_consecutive", 32'(wr_cyc[wi+i] - wr_cyc[wi]), 32'(i));
    end else begin
      checks++;
      errors++;
      $display("FAIL tput_write_log actual=%0d required=8", wr_cyc.size() - wi);
    end

    // Illegal op mid-session
    w0 = wr_cnt; d0 = done_cnt;
    do_start(32'h00003000, 16'd3, sc);
    send(illeg[0], hs, ft);
    chk("illegal_err_before", 32'(err), 32'd0);
    send(illeg[1], hs, ft);
    chk("illegal_err_next_cycle", 32'(err), 32'd1);
    send(illeg[2], hs, ft);
    in_valid = 1'b0;
    wait_done(30, dc);
    idle_cycles(4);
    chk("illegal_writes", 32'(wr_cnt - w0), 32'd2);
    chk("illegal_done_once", 32'(done_cnt - d0), 32'd1);
    chk("illegal_err_sticky", 32'(err), 32'd1);

    // count == 0: start clears err, done follows without writes
    w0 = wr_cnt; d0 = done_cnt; miss = 0;
    do_start(32'h00004000, 16'd0, sc);
    chk("zero_err_cleared", 32'(err), 32'd0);
    dc = (done === 1'b1) ? cyc : -1;
    if (dc < 0) wait_done(5, dc);
    chk("zero_done_latency", 32'((dc >= 0) && (dc - sc) <= 2), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (in_ready) miss++;
    end
    chk("zero_in_ready_low", 32'(miss), 32'd0);
    chk("zero_writes", 32'(wr_cnt - w0), 32'd0);
    chk("zero_done_once", 32'(done_cnt - d0), 32'd1);

    // Address wrap and a start ignored mid-session
    w0 = wr_cnt; d0 = done_cnt;
    do_start(32'hFFFFFFFC, 16'd2, sc);
    send(allops[0], hs, ft);
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = 32'h00005000; count = 16'd7;
    @(negedge clk);
    start = 1'b0;
    chk("wrap_busy_after_start", 32'(busy), 32'd1);
    send(allops[1], hs, ft);
    in_valid = 1'b0;
    wait_done(30, dc);
    idle_cycles(3);
    chk("wrap_writes", 32'(wr_cnt - w0), 32'd2);
    chk("wrap_done_once", 32'(done_cnt - d0), 32'd1);
    chk("wrap_last_addr", imem_addr, 32'h00000000);

    // Reset in DRAIN aborts the session
    do_start(32'h00006000, 16'd3, sc);
    for (int i = 0; i < 3; i++) send(basic[i], hs, ft);
    rst_n = 1'b0;
    #1;
    in_valid = 1'b0;
    chk("abort_imem_we", 32'(imem_we), 32'd0);
    chk("abort_imem_addr", imem_addr, 32'd0);
    chk("abort_imem_wdata", imem_wdata, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    w0 = wr_cnt; d0 = done_cnt;
    idle_cycles(10);
    chk("abort_no_writes", 32'(wr_cnt - w0), 32'd0);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
